// File: rtl/csa_final_adder_pipe.sv
// Two-stage final adder that resolves a carry-save (sum, carry) pair into binary.
// Stage 1 adds the low segment; stage 2 adds the high segment plus the low carry-out.
module csa_final_adder_pipe #(
  parameter int unsigned S_WIDTH  = 20,
  parameter int unsigned C_WIDTH  = 20,
  parameter int unsigned LO_WIDTH = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [S_WIDTH-1:0] s_in,
  input  logic [C_WIDTH-1:0] c_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [S_WIDTH:0]   sum_out,
  output logic [1:0]         occupancy
);

  localparam int unsigned HiWidth = S_WIDTH - LO_WIDTH;

  logic                v1_q, v2_q;
  logic [LO_WIDTH-1:0] lo_q;
  logic                k_q;
  logic [HiWidth-1:0]  s_hi_q, c_hi_q;
  logic [S_WIDTH:0]    sum_q;

  logic                adv1, adv2, load1, load2;
  logic [LO_WIDTH:0]   lo_sum;
  logic [HiWidth:0]    hi_sum;

  always_comb begin
    adv2   = !v2_q || out_ready;
    adv1   = !v1_q || adv2;
    // Data only moves with a valid pair, so invalid inputs never disturb held results.
    load1  = adv1 && in_valid;
    load2  = adv2 && v1_q;
    lo_sum = {1'b0, s_in[LO_WIDTH-1:0]} + {1'b0, c_in[LO_WIDTH-1:0]};
    hi_sum = {1'b0, s_hi_q} + {1'b0, c_hi_q} + {{HiWidth{1'b0}}, k_q};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
    end else begin
      if (adv1) v1_q <= in_valid;
      if (adv2) v2_q <= v1_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lo_q   <= '0;
      k_q    <= 1'b0;
      s_hi_q <= '0;
      c_hi_q <= '0;
    end else if (load1) begin
      lo_q   <= lo_sum[LO_WIDTH-1:0];
      k_q    <= lo_sum[LO_WIDTH];
      s_hi_q <= s_in[S_WIDTH-1:LO_WIDTH];
      c_hi_q <= c_in[S_WIDTH-1:LO_WIDTH];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q <= '0;
    end else if (load2) begin
      sum_q <= {hi_sum, lo_q};
    end
  end

  assign in_ready  = adv1;
  assign out_valid = v2_q;
  assign sum_out   = sum_q;
  assign occupancy = {1'b0, v1_q} + {1'b0, v2_q};

endmodule

// File: tb/tb_csa_final_adder_pipe.sv
// Directed bench for csa_final_adder_pipe: latency, boundary sums, stall, reset and
// a randomized in-order scoreboard run. Inputs change and outputs are sampled near negedge.
module tb_csa_final_adder_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [19:0] s_in;
  logic [19:0] c_in;
  logic        out_valid;
  logic        out_ready;
  logic [20:0] sum_out;
  logic [1:0]  occupancy;

  int n_vec = 0;
  int n_err = 0;

  csa_final_adder_pipe #(
    .S_WIDTH (20),
    .C_WIDTH (20),
    .LO_WIDTH(10)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .s_in     (s_in),
    .c_in     (c_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sum_out  (sum_out),
    .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One pair through an otherwise empty pipe with out_ready high.
  task automatic single(input logic [19:0] s, input logic [19:0] c, input logic [20:0] exp,
                        input string tag);
    s_in      = s;
    c_in      = c;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    #1 chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
    #1 chk({tag, "_occ1"}, 64'(occupancy), 64'd1);
    chk({tag, "_not_yet"}, 64'(out_valid), 64'd0);
    @(negedge clk);
    #1 chk({tag, "_valid"}, 64'(out_valid), 64'd1);
    chk({tag, "_sum"}, 64'(sum_out), 64'(exp));
    @(negedge clk);
    #1 chk({tag, "_drained"}, 64'(out_valid), 64'd0);
    chk({tag, "_occ0"}, 64'(occupancy), 64'd0);
  endtask

  logic [20:0] exp_q[$];
  logic [20:0] e;
  int          sent, got, cyc;

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    s_in      = '0;
    c_in      = '0;
    @(negedge clk);
    @(negedge clk);
    #1 chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_occ", 64'(occupancy), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_sum", 64'(sum_out), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Boundary sums
    single(20'hFFFFF, 20'h00001, 21'h100000, "wrap_top");
    single(20'h003FF, 20'h00001, 21'h000400, "lo_carry");
    single(20'hFFFFF, 20'hFFFFF, 21'h1FFFFE, "all_ones");

    // Back-pressure: third pair must wait
    out_ready = 1'b0;
    in_valid  = 1'b1;
    s_in = 20'd1; c_in = 20'd2;
    #1 chk("bp_acc1", 64'(in_ready), 64'd1);
    @(negedge clk);
    s_in = 20'd3; c_in = 20'd4;
    #1 chk("bp_acc2", 64'(in_ready), 64'd1);
    @(negedge clk);
    s_in = 20'd5; c_in = 20'd6;
    #1 chk("bp_blocked", 64'(in_ready), 64'd0);
    chk("bp_occ2", 64'(occupancy), 64'd2);
    chk("bp_valid", 64'(out_valid), 64'd1);
    chk("bp_sum3", 64'(sum_out), 64'd3);
    @(negedge clk);
    #1 chk("bp_stable_sum", 64'(sum_out), 64'd3);
    chk("bp_stable_occ", 64'(occupancy), 64'd2);
    chk("bp_still_blocked", 64'(in_ready), 64'd0);
    out_ready = 1'b1;
    #1 chk("bp_release_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
    #1 chk("bp_out7", 64'(sum_out), 64'd7);
    chk("bp_out7_valid", 64'(out_valid), 64'd1);
    @(negedge clk);
    #1 chk("bp_out11", 64'(sum_out), 64'd11);
    chk("bp_out11_valid", 64'(out_valid), 64'd1);
    @(negedge clk);
    #1 chk("bp_empty", 64'(out_valid), 64'd0);

    // Full pipe streaming: accept, shift and emit every cycle
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 8; i++) begin
      s_in = 20'(i * 100);
      c_in = 20'(i);
      #1;
      if (i >= 2) begin
        chk("stream_occ2", 64'(occupancy), 64'd2);
        chk("stream_valid", 64'(out_valid), 64'd1);
        chk("stream_sum", 64'(sum_out), 64'((i - 2) * 101));
        chk("stream_ready", 64'(in_ready), 64'd1);
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);

    // Reset mid-flight with pipe full
    out_ready = 1'b0;
    in_valid  = 1'b1;
    s_in = 20'd7; c_in = 20'd8;
    @(negedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    #1 chk("pre_rst_occ2", 64'(occupancy), 64'd2);
    rst = 1'b1;
    #1 chk("async_rst_valid", 64'(out_valid), 64'd0);
    chk("async_rst_occ", 64'(occupancy), 64'd0);
    chk("async_rst_ready", 64'(in_ready), 64'd1);
    chk("async_rst_sum", 64'(sum_out), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    #1 chk("post_rst_no_stale", 64'(out_valid), 64'd0);
    single(20'd10, 20'd20, 21'd30, "post_rst");

    // Random traffic with random back-pressure
    sent = 0;
    got  = 0;
    cyc  = 0;
    while (got < 100 && cyc < 3000) begin
      in_valid  = (sent < 100) && ($urandom_range(0, 3) != 0);
      s_in      = 20'($urandom);
      c_in      = 20'($urandom);
      out_ready = ($urandom_range(0, 2) != 0);
      #1;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("rnd_extra_output", 64'd1, 64'd0);
        end else begin
          e = exp_q.pop_front();
          chk("rnd_sum", 64'(sum_out), 64'(e));
        end
        got++;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(21'(s_in) + 21'(c_in));
        sent++;
      end
      @(negedge clk);
      cyc++;
    end
    in_valid = 1'b0;
    chk("rnd_count", 64'(got), 64'd100);
    chk("rnd_sent", 64'(sent), 64'd100);
    chk("rnd_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/csa_final_adder_pipe.md
CSA_FINAL_ADDER_PIPE -- requirements
Module: csa_final_adder_pipe

Interface
REQ-001 SHALL have parameter S_WIDTH, default 20: width of the carry-save sum vector.
REQ-002 SHALL have parameter C_WIDTH, default 20: width of the carry-save carry vector; C_WIDTH SHALL equal S_WIDTH.
REQ-003 SHALL have parameter LO_WIDTH, default 10: width of the low segment added in stage 1; 1 <= LO_WIDTH < S_WIDTH.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port in_valid, input, 1 bit: the input pair is valid.
REQ-007 SHALL have port in_ready, output, 1 bit: the block accepts the input pair this cycle.
REQ-008 SHALL have port s_in, input, S_WIDTH bits: carry-save sum vector (LSB = bit weight 1).
REQ-009 SHALL have port c_in, input, C_WIDTH bits: carry-save carry vector, already weight-aligned to s_in, so bit 0 is normally 0.
REQ-010 SHALL have port out_valid, output, 1 bit: the result is valid.
REQ-011 SHALL have port out_ready, input, 1 bit: the downstream accepts the result.
REQ-012 SHALL have port sum_out, output, S_WIDTH+1 bits: resolved binary sum.
REQ-013 SHALL have port occupancy, output, 2 bits: number of valid stages (0..2).

Function
REQ-014 Input handshake SHALL fire when in_valid && in_ready; output handshake SHALL fire when out_valid && out_ready.
REQ-015 Stage 1 SHALL register the following: lo = s_in[LO_WIDTH-1:0] + c_in[LO_WIDTH-1:0] (LO_WIDTH bits), carry-out bit k, the upper segments of s_in and c_in, and v1.
REQ-016 Stage 2 SHALL register sum_out = {s_hi + c_hi + k, lo} (S_WIDTH+1 bits, no truncation) and v2; out_valid SHALL equal v2.
REQ-017 adv2 = !v2 || out_ready; adv1 = !v1 || adv2; in_ready SHALL equal adv1 (combinational, no in_valid dependency).
REQ-018 When adv2 is true, stage 2 SHALL load stage 1 contents and v2 <= v1; otherwise it SHALL hold.
REQ-019 When adv1 is true, stage 1 SHALL load the input and v1 <= in_valid; otherwise it SHALL hold.
REQ-020 Latency SHALL be 2 cycles from input handshake to out_valid; throughput SHALL be 1 result per cycle with out_ready held high.
REQ-021 Results SHALL leave in acceptance order; no result SHALL be lost or duplicated under any out_ready pattern.
REQ-022 While out_valid && !out_ready, sum_out SHALL remain stable.
REQ-023 occupancy SHALL equal v1 + v2.
REQ-024 Data registers SHALL be updated only on a stage load; an invalid stage's data is don't-care, but the load SHALL be deterministic (no X propagation into valid data).
REQ-025 When the pipe is full (v1 = v2 = 1) with out_ready = 1 and in_valid = 1, the block SHALL simultaneously accept, shift, and emit, with occupancy remaining 2.

Reset
REQ-026 On rst = 1, v1 and v2 SHALL clear immediately (asynchronously), giving out_valid = 0, occupancy = 0, and in_ready = 1.
REQ-027 On rst = 1, sum_out SHALL reset to 0, and stage 1 data registers SHALL reset to 0.
REQ-028 Reset asserted mid-operation SHALL discard all in-flight pairs; the first handshake after deassertion SHALL produce its result 2 cycles later.

Verification
REQ-029 s_in = 20'hFFFFF, c_in = 20'h00001, out_ready = 1 -> sum_out = 21'h100000 two cycles later.
REQ-030 s_in = 20'h003FF, c_in = 20'h00001 (carry across the LO_WIDTH boundary) -> 21'h000400; s_in = c_in = 20'hFFFFF -> 21'h1FFFFE.
REQ-031 Send 3 back-to-back pairs (1+2, 3+4, 5+6) with out_ready = 0 -> 2 are accepted, then in_ready = 0 and occupancy = 2; raise out_ready -> outputs 3, 7, 11 in order, and sum_out is stable while stalled.
REQ-032 100 random pairs with random out_ready -> every output equals s_in + c_in, in order, with count 100.
REQ-033 Assert rst with occupancy = 2 -> out_valid = 0 within the same cycle (before the clock edge); after release, input 10+20 -> 30 appears 2 cycles after acceptance, with no stale outputs.
REQ-034 Full pipe, out_ready = 1, in_valid = 1 continuously -> one result per cycle and occupancy stays 2.
